// File: rtl/axis_gearbox_flex_if.sv
// -----------------------------------------------------------------------------
// axis_gearbox_flex_if
// Bundles both stream sides of the gearbox plus its fill-level output.
//   slave  modport : the gearbox itself (sinks in_*, sources out_* and level)
//   master modport : the environment (sources in_* and out_ready)
// Signals:
//   in_valid/in_ready/in_data[IN_W]/in_last      upstream beat handshake
//   out_valid/out_ready/out_data[OUT_W]/out_last downstream word handshake
//   out_fill[FILL_W]                             valid LSBs in out_data
//   level[CNT_W]                                 bits held in the buffer
// -----------------------------------------------------------------------------
interface axis_gearbox_flex_if #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 32
);
  localparam int BUF_W  = 2 * (IN_W + OUT_W);
  localparam int CNT_W  = $clog2(BUF_W + 1);
  localparam int FILL_W = $clog2(OUT_W + 1);

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;
  logic [FILL_W-1:0] out_fill;
  logic [CNT_W-1:0]  level;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_fill, level
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_fill, level
  );
endinterface

// File: rtl/axis_gearbox_flex.sv
// -----------------------------------------------------------------------------
// axis_gearbox_flex
// Width converter between an IN_W-bit and an OUT_W-bit AXI-stream with packet
// boundaries. Beats and words form one LSB-first bit stream; a packet's final
// word may be partial and reports its valid bit count on out_fill.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    axis_gearbox_flex_if.slave (input stream, output stream, level)
// Both in_ready and out_valid come from registered state only, so there is no
// combinational path through the block in either direction.
// -----------------------------------------------------------------------------
module axis_gearbox_flex #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  axis_gearbox_flex_if.slave  bus
);

  localparam int BUF_W  = 2 * (IN_W + OUT_W);
  localparam int CNT_W  = $clog2(BUF_W + 1);
  localparam int FILL_W = $clog2(OUT_W + 1);

  // Bit buffer: bit 0 is the oldest bit held. Everything at or above cnt_q is
  // kept zero, which is what makes out_data's unused upper bits read as zero.
  logic [BUF_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_last_q, pend_last_d;

  logic             in_ready_w;
  logic             out_valid_w;
  logic             out_last_w;
  logic             in_fire;
  logic             out_fire;
  logic [CNT_W-1:0] pop_cnt;

  // Room for a whole beat, and no packet tail still waiting to leave.
  assign in_ready_w  = (cnt_q <= CNT_W'(BUF_W - IN_W)) && !pend_last_q;
  // A full word, or whatever remains of a packet whose last beat is in.
  assign out_valid_w = (cnt_q >= CNT_W'(OUT_W)) || (pend_last_q && (cnt_q != '0));
  assign out_last_w  = pend_last_q && (cnt_q <= CNT_W'(OUT_W));

  assign in_fire  = bus.in_valid && in_ready_w;
  assign out_fire = bus.out_ready && out_valid_w;

  // A final word may carry fewer than OUT_W bits; pop only what is there.
  assign pop_cnt = (cnt_q >= CNT_W'(OUT_W)) ? CNT_W'(OUT_W) : cnt_q;

  always_comb begin
    // NOTE: every variable gets its default before any branch, so no path can
    // leave one unassigned and infer a latch.
    bits_d      = bits_q;
    cnt_d       = cnt_q;
    pend_last_d = pend_last_q;

    // Pop first, then append above whatever survives, so a simultaneous
    // push and pop neither loses nor duplicates bits.
    if (out_fire) begin
      bits_d = bits_q >> OUT_W;
      cnt_d  = cnt_q - pop_cnt;
      if (out_last_w) begin
        pend_last_d = 1'b0;
      end
    end

    if (in_fire) begin
      bits_d = bits_d | (BUF_W'(bus.in_data) << cnt_d);
      cnt_d  = cnt_d + CNT_W'(IN_W);
      if (bus.in_last) begin
        pend_last_d = 1'b1;
      end
    end
  end

  // NOTE: the buffer is reset along with the counters, not left to hold
  // stale data, because the zero-above-cnt invariant depends on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q      <= '0;
      cnt_q       <= '0;
      pend_last_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      bits_q      <= bits_d;
      cnt_q       <= cnt_d;
      pend_last_q <= pend_last_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = bits_q[OUT_W-1:0];
  assign bus.out_last  = out_last_w;
  // Reads zero when nothing is offered, so the idle/reset value is clean.
  assign bus.out_fill  = !out_valid_w ? '0 :
                         out_last_w   ? FILL_W'(cnt_q) : FILL_W'(OUT_W);
  assign bus.level     = cnt_q;

endmodule

// File: tb/tb_axis_gearbox_flex.sv
// -----------------------------------------------------------------------------
// tb_axis_gearbox_flex
// Four gearbox instances (24->32, 32->24, 16->8, 8->8) on one clock and reset.
// Inputs change and outputs are sampled on the falling edge; transfers happen
// on the rising edge in between.
// -----------------------------------------------------------------------------
module tb_axis_gearbox_flex;

  localparam int U0_IN  = 24;
  localparam int U0_OUT = 32;
  localparam int U0_BUF = 2 * (U0_IN + U0_OUT);
  localparam int RND_BEATS   = 10000;
  localparam int RND_MAX_CYC = 60000;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axis_gearbox_flex_if #(.IN_W(24), .OUT_W(32)) if0 ();
  axis_gearbox_flex_if #(.IN_W(32), .OUT_W(24)) if1 ();
  axis_gearbox_flex_if #(.IN_W(16), .OUT_W(8))  if2 ();
  axis_gearbox_flex_if #(.IN_W(8),  .OUT_W(8))  if3 ();

  axis_gearbox_flex #(.IN_W(24), .OUT_W(32)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  axis_gearbox_flex #(.IN_W(32), .OUT_W(24)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  axis_gearbox_flex #(.IN_W(16), .OUT_W(8))  u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  axis_gearbox_flex #(.IN_W(8),  .OUT_W(8))  u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- table-driven packet on the 24->32 instance --------------
  // Each record: outputs expected at this falling edge, then inputs driven
  // for the following rising edge.
  typedef struct {
    logic        in_valid;
    logic [23:0] in_data;
    logic        in_last;
    logic        out_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_last;
    logic [5:0]  exp_fill;
    logic [6:0]  exp_level;
    logic        exp_in_ready;
  } vec_t;

  vec_t vecs[6];

  task automatic run_table(input string tag);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s%0d_valid", tag, i), if0.out_valid, vecs[i].exp_valid);
      check($sformatf("%s%0d_level", tag, i), if0.level, vecs[i].exp_level);
      check($sformatf("%s%0d_in_ready", tag, i), if0.in_ready, vecs[i].exp_in_ready);
      if (vecs[i].exp_valid) begin
        check($sformatf("%s%0d_data", tag, i), if0.out_data, vecs[i].exp_data);
        check($sformatf("%s%0d_last", tag, i), if0.out_last, vecs[i].exp_last);
        check($sformatf("%s%0d_fill", tag, i), if0.out_fill, vecs[i].exp_fill);
      end
      if0.in_valid  = vecs[i].in_valid;
      if0.in_data   = vecs[i].in_data;
      if0.in_last   = vecs[i].in_last;
      if0.out_ready = vecs[i].out_ready;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"},     if0.level, 0);
    check({tag, "_out_valid"}, if0.out_valid, 0);
    check({tag, "_out_last"},  if0.out_last, 0);
    check({tag, "_out_fill"},  if0.out_fill, 0);
    check({tag, "_in_ready"},  if0.in_ready, 1);
    check({tag, "_u1_valid"},  if1.out_valid, 0);
    check({tag, "_u2_level"},  if2.level, 0);
  endtask

  // ---------------- 32->24: one beat splits into a full and a partial word --
  task automatic run_u1();
    check("u1_idle_in_ready", if1.in_ready, 1);
    if1.in_valid  = 1'b1;
    if1.in_data   = 32'hDDCCBBAA;
    if1.in_last   = 1'b1;
    if1.out_ready = 1'b1;
    @(negedge clk);
    if1.in_valid = 1'b0;
    if1.in_last  = 1'b0;
    check("u1_w0_valid", if1.out_valid, 1);
    check("u1_w0_data",  if1.out_data, 24'hCCBBAA);
    check("u1_w0_last",  if1.out_last, 0);
    check("u1_w0_fill",  if1.out_fill, 24);
    check("u1_w0_in_ready", if1.in_ready, 0);
    @(negedge clk);
    check("u1_w1_valid", if1.out_valid, 1);
    check("u1_w1_data",  if1.out_data, 24'h0000DD);
    check("u1_w1_last",  if1.out_last, 1);
    check("u1_w1_fill",  if1.out_fill, 8);
    check("u1_w1_in_ready", if1.in_ready, 0);
    @(negedge clk);
    check("u1_done_valid", if1.out_valid, 0);
    check("u1_done_in_ready", if1.in_ready, 1);
    check("u1_done_level", if1.level, 0);
    if1.out_ready = 1'b0;
  endtask

  // ---------------- 16->8: fill to the brim with output stalled, then drain -
  task automatic run_u2();
    int acc = 0;
    if2.out_ready = 1'b0;
    if2.in_last   = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if2.in_valid = 1'b1;
      if2.in_data  = {8'(2 * acc + 1), 8'(2 * acc)};
      if (if2.in_ready) acc++;
      @(negedge clk);
    end
    check("u2_accepted", acc, 3);
    check("u2_full_in_ready", if2.in_ready, 0);
    check("u2_full_level", if2.level, 48);
    check("u2_stall_data", if2.out_data, 8'h00);
    if2.in_valid  = 1'b0;
    if2.out_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      check($sformatf("u2_drain%0d_valid", b), if2.out_valid, 1);
      check($sformatf("u2_drain%0d_data", b), if2.out_data, b);
      @(negedge clk);
    end
    check("u2_empty_valid", if2.out_valid, 0);
    check("u2_empty_level", if2.level, 0);
    if2.out_ready = 1'b0;
  endtask

  // ---------------- 8->8: register stage, one word per cycle ----------------
  task automatic run_u3();
    if3.out_ready = 1'b1;
    if3.in_last   = 1'b0;
    for (int k = 0; k <= 256; k++) begin
      if (k >= 1) begin
        check($sformatf("u3_k%0d_valid", k), if3.out_valid, 1);
        check($sformatf("u3_k%0d_data", k), if3.out_data, k - 1);
      end
      if (k < 256) begin
        check($sformatf("u3_k%0d_in_ready", k), if3.in_ready, 1);
        if3.in_valid = 1'b1;
        if3.in_data  = 8'(k);
      end else begin
        if3.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("u3_end_valid", if3.out_valid, 0);
    if3.out_ready = 1'b0;
  endtask

  // ---------------- reference model for the 24->32 instance -----------------
  // Packet bits collected in a queue; a word is due as soon as OUT bits of the
  // packet are available, and the packet tail becomes a word when its last
  // beat arrives.
  typedef struct {
    logic [31:0] data;
    logic        last;
    int          fill;
  } word_t;

  word_t sb[$];
  bit    pkt_bits[$];
  int    model_level;
  bit    model_pend;

  function automatic void emit(input int n, input bit last);
    word_t w;
    w.data = '0;
    for (int i = 0; i < n; i++) w.data[i] = pkt_bits.pop_front();
    w.last = last;
    w.fill = n;
    sb.push_back(w);
  endfunction

  function automatic void model_push(input logic [23:0] d, input bit last);
    for (int i = 0; i < U0_IN; i++) pkt_bits.push_back(d[i]);
    model_level += U0_IN;
    while (pkt_bits.size() >= U0_OUT) emit(U0_OUT, last && (pkt_bits.size() == U0_OUT));
    if (last && (pkt_bits.size() > 0)) emit(pkt_bits.size(), 1'b1);
    if (last) model_pend = 1'b1;
  endfunction

  task automatic run_random(input int n_beats);
    int          sent = 0;
    int          cyc = 0;
    bit          pending = 1'b0;
    logic [23:0] d = '0;
    bit          l = 1'b0;
    sb.delete();
    pkt_bits.delete();
    model_level = 0;
    model_pend  = 1'b0;
    while ((sent < n_beats) || pending || (sb.size() != 0)) begin
      if (cyc >= RND_MAX_CYC) begin
        checks++;
        errors++;
        $display("FAIL rnd_timeout: got %0d beats sent, %0d words outstanding, expected completion within %0d cycles",
                 sent, sb.size(), RND_MAX_CYC);
        break;
      end
      check("rnd_level", if0.level, model_level);
      check("rnd_in_ready", if0.in_ready, (model_level <= U0_BUF - U0_IN) && !model_pend);
      check("rnd_out_valid", if0.out_valid, sb.size() != 0);
      if (if0.out_valid && (sb.size() != 0)) begin
        check("rnd_data", if0.out_data, sb[0].data);
        check("rnd_last", if0.out_last, sb[0].last);
        check("rnd_fill", if0.out_fill, sb[0].fill);
      end
      // Beats, once offered, stay offered until taken.
      if (!pending && (sent < n_beats) && ($urandom_range(1) == 1)) begin
        d = 24'($urandom);
        sent++;
        l = (sent == n_beats) || ($urandom_range(7) == 0);
        pending = 1'b1;
        if0.in_data = d;
        if0.in_last = l;
      end
      if0.in_valid  = pending;
      if0.out_ready = 1'($urandom_range(1));
      if (if0.out_valid && if0.out_ready && (sb.size() != 0)) begin
        model_level -= sb[0].fill;
        if (sb[0].last) model_pend = 1'b0;
        void'(sb.pop_front());
      end
      if (pending && if0.in_ready) begin
        model_push(d, l);
        pending = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if0.in_valid  = 1'b0;
    if0.out_ready = 1'b0;
  endtask

  // ---------------- main sequence ------------------------------------------
  initial begin
    vecs[0] = '{1'b1, 24'hCCBBAA, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 6'd0,  7'd0,  1'b1};
    vecs[1] = '{1'b1, 24'hFFEEDD, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 6'd0,  7'd24, 1'b1};
    vecs[2] = '{1'b1, 24'h332211, 1'b0, 1'b1, 1'b1, 32'hDDCCBBAA, 1'b0, 6'd32, 7'd48, 1'b1};
    vecs[3] = '{1'b1, 24'h665544, 1'b1, 1'b1, 1'b1, 32'h2211FFEE, 1'b0, 6'd32, 7'd40, 1'b1};
    vecs[4] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 32'h66554433, 1'b1, 6'd32, 7'd32, 1'b0};
    vecs[5] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 6'd0,  7'd0,  1'b1};

    if0.in_valid = 1'b0; if0.in_data = '0; if0.in_last = 1'b0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.in_last = 1'b0; if1.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.in_data = '0; if2.in_last = 1'b0; if2.out_ready = 1'b0;
    if3.in_valid = 1'b0; if3.in_data = '0; if3.in_last = 1'b0; if3.out_ready = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    // Release and start the first packet in the same half-cycle, so the very
    // next rising edge must already accept a beat.
    rst_n = 1'b1;
    run_table("tblA_");

    run_u1();
    run_u2();
    run_u3();
    run_random(RND_BEATS);

    // Mid-packet reset: 72 bits in, one word out, 40 bits left behind.
    if0.out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      if0.in_valid = 1'b1;
      if0.in_data  = 24'($urandom);
      if0.in_last  = 1'b0;
      @(negedge clk);
    end
    if0.in_valid  = 1'b0;
    if0.out_ready = 1'b1;
    @(negedge clk);
    if0.out_ready = 1'b0;
    check("midpkt_level", if0.level, 40);
    check("midpkt_valid", if0.out_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_table("tblB_");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_gearbox_flex.md
AXIS_GEARBOX_FLEX -- requirements
Module: axis_gearbox_flex

Interface
REQ-001 Parameter IN_W, default 24, input data width in bits, SHALL be >= 1.
REQ-002 Parameter OUT_W, default 32, output data width in bits, SHALL be >= 1; no divisibility relation to IN_W is required.
REQ-003 Derived constants: BUF_W = 2*(IN_W+OUT_W); CNT_W = $clog2(BUF_W+1); FILL_W = $clog2(OUT_W+1).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream beat valid.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_data  input  IN_W  upstream payload.
REQ-009 in_last  input  1  beat closes the current packet.
REQ-010 out_valid  output  1  output word valid.
REQ-011 out_ready  input  1  downstream accepts a word.
REQ-012 out_data  output  OUT_W  output payload; unused upper bits are zero.
REQ-013 out_last  output  1  word is the final word of a packet.
REQ-014 out_fill  output  FILL_W  number of valid LSBs in out_data: OUT_W on non-last words, 1..OUT_W on the last word.
REQ-015 level  output  CNT_W  bits currently held in the buffer.

Function
REQ-016 Beats and words SHALL be treated as one LSB-first bit stream; the first bit accepted is bit 0 of the first output word.
REQ-017 Handshakes SHALL follow AXI-stream rules: a transfer occurs when valid and ready are both high on a rising edge; out_valid, out_data, out_last and out_fill SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 State: bit buffer of BUF_W bits, bit counter cnt (0..BUF_W) and flag pend_last.
REQ-019 in_ready SHALL be (cnt <= BUF_W-IN_W) and not pend_last, and SHALL depend on registered state only, with no combinational path from out_ready or in_valid.
REQ-020 out_valid SHALL be (cnt >= OUT_W) or (pend_last and cnt > 0), and SHALL depend on registered state only.
REQ-021 out_last SHALL be pend_last and (cnt <= OUT_W); out_fill SHALL be OUT_W when out_last=0 and cnt otherwise.
REQ-022 On an output transfer, the low OUT_W bits SHALL be removed and cnt SHALL decrease by min(OUT_W, cnt).
REQ-023 On an input transfer, in_data SHALL be appended above the remaining bits and cnt SHALL increase by IN_W.
REQ-024 A simultaneous input and output transfer SHALL apply both in the same cycle: new cnt = cnt - popped + IN_W, and no data SHALL be lost or duplicated.
REQ-025 An accepted beat with in_last=1 SHALL set pend_last; pend_last SHALL clear on the transfer of the word with out_last=1.
REQ-026 No new beat SHALL be accepted until that word has transferred.
REQ-027 Latency: a word SHALL be presented on out_valid the cycle after the input transfer that completes it.
REQ-028 With in_valid and out_ready held high, throughput SHALL be min(IN_W, OUT_W) bits per cycle in steady state, with no bubbles caused by buffer sizing.
REQ-029 IN_W == OUT_W SHALL behave as a 1-cycle-latency register stage with full throughput.
REQ-030 level SHALL equal cnt.

Reset
REQ-031 While rst_n=0, cnt=0, pend_last=0, buffer=0, out_valid=0, out_last=0, out_fill=0, level=0 and in_ready=1 SHALL hold, asserted asynchronously.
REQ-032 Reset asserted mid-packet SHALL discard all buffered bits, and no partial word SHALL appear after deassertion.
REQ-033 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-034 IN_W=24, OUT_W=32: beats 0xCCBBAA, 0xFFEEDD, 0x332211, 0x665544 (last on the 4th), out_ready=1 -> output words 0xDDCCBBAA, 0x2211FFEE, 0x66554433 (last, fill=32).
REQ-035 IN_W=32, OUT_W=24: single beat 0xDDCCBBAA with in_last=1 -> output words 0xCCBBAA (fill=24, last=0), then 0x0000DD (last=1, fill=8); in_ready=0 until the second word transfers.
REQ-036 IN_W=16, OUT_W=8, out_ready=0, in_valid=1 -> exactly 3 beats accepted, then in_ready=0 and level=48; out_ready=1 then drains the buffer in byte order.
REQ-037 IN_W=OUT_W=8, continuous stream 0x00..0xFF with out_ready=1 -> one word per cycle, 1-cycle latency, no bubbles.
REQ-038 Random out_ready and in_valid (50%) over 10k beats, random in_last -> output bit stream equals input bit stream, with packet boundaries and out_fill matching a reference model.
REQ-039 rst_n pulsed low mid-packet with level=40 -> level=0 and out_valid=0 immediately; the next packet passes uncorrupted.
